// File: rtl/rca_share_seq.sv
// Two-requester arbiter around one shared 4-bit ripple-carry adder.
// Each WIDTH-bit add is sequenced LSB nibble first, carry held in a register.
module rca_share_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             id_q;
  logic             valid_q;
  logic             last_grant_q;
  logic [CW-1:0]    cnt_q;
  logic             grant1;
  logic [4:0]       nib_add;

  // Round-robin: requester 1 wins if alone, or on a tie when 0 had the last grant.
  assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = rst_n & (state_q == IDLE) & req0_valid & ~grant1;
  assign req1_ready = rst_n & (state_q == IDLE) & grant1;

  // Operands are shifted right each pass, so the active nibble is always [3:0].
  assign nib_add = 5'(a_q[3:0]) + 5'(b_q[3:0]) + 5'(carry_q);

  assign res_valid = valid_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      valid_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            a_q          <= req1_ready ? req1_a   : req0_a;
            b_q          <= req1_ready ? req1_b   : req0_b;
            carry_q      <= req1_ready ? req1_cin : req0_cin;
            id_q         <= req1_ready;
            last_grant_q <= req1_ready;
            cnt_q        <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= nib_add[4];
          // New nibble enters at the top; after NIBBLES passes it lands in place.
          sum_q   <= (sum_q >> 4) | (WIDTH'(nib_add[3:0]) << (WIDTH - 4));
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NIBBLES - 1)) begin
            cout_q  <= nib_add[4];
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_share_seq.sv
// Self-checking bench for rca_share_seq: directed table, random ops against an
// arithmetic reference, round-robin alternation, backpressure and reset abort.
module tb_rca_share_seq;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout, res_id, busy;

  int checks = 0;
  int errors = 0;

  rca_share_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           cin;
    logic [W-1:0] sum;
    bit           cout;
  } vec_t;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit cin);
    return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(res_valid), 0);
    chk({tag, "_sum"},   32'(res_sum),   0);
    chk({tag, "_cout"},  32'(res_cout),  0);
    chk({tag, "_id"},    32'(res_id),    0);
    chk({tag, "_rdy"},   32'({req0_ready, req1_ready}), 0);
    chk({tag, "_busy"},  32'(busy),      0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation: present the request(s), check grant, latency, result,
  // hold the result under backpressure for bp cycles, then accept it.
  task automatic op(input bit v0, input bit v1,
                    input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0,
                    input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1,
                    input bit exp_id, input logic [W-1:0] exp_sum, input bit exp_cout,
                    input int bp);
    int n;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    res_ready  = 1'b0;
    #1;
    chk("grant", 32'({req1_ready, req0_ready}), exp_id ? 32'h2 : 32'h1);
    @(posedge clk);
    @(negedge clk);
    // Perturb operands after the handshake; the result must not follow them.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
    chk("busy_run", 32'(busy), 1);
    n = 1;
    while (!res_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 5);
    chk("sum", 32'(res_sum), 32'(exp_sum));
    chk("cout", 32'(res_cout), 32'(exp_cout));
    chk("id", 32'(res_id), 32'(exp_id));
    for (int i = 0; i < bp; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("bp_ready", 32'({req0_ready, req1_ready}), 0);
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_sum", 32'(res_sum), 32'(exp_sum));
      chk("bp_id", 32'(res_id), 32'(exp_id));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready  = 1'b1;
    @(negedge clk);
    chk("accept_valid", 32'(res_valid), 0);
    chk("accept_busy", 32'(busy), 0);
    res_ready = 1'b0;
  endtask

  vec_t         vecs[6];
  logic [W:0]   r;
  logic [W-1:0] ra[2], rb[2];
  bit           rc[2];
  bit           last, g, pend, seen;
  int           cyc, prev_c, ngrant, n;
  logic [W-1:0] exp_s;
  bit           exp_c, exp_i;

  initial begin
    vecs[0] = '{id: 1'b0, a: 16'h1234, b: 16'h0FFF, cin: 1'b0, sum: 16'h2233, cout: 1'b0};
    vecs[1] = '{id: 1'b1, a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    vecs[2] = '{id: 1'b1, a: 16'h7FFF, b: 16'h0000, cin: 1'b1, sum: 16'h8000, cout: 1'b0};
    vecs[3] = '{id: 1'b0, a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
    vecs[4] = '{id: 1'b1, a: 16'hABCD, b: 16'h1111, cin: 1'b1, sum: 16'hBCDF, cout: 1'b0};
    vecs[5] = '{id: 1'b0, a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    do_reset();
    chk_zero("reset");

    // Directed table; vector 0 also exercises 3 cycles of backpressure.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].id)
        op(1'b0, 1'b1, '0, '0, 1'b0, vecs[i].a, vecs[i].b, vecs[i].cin,
           1'b1, vecs[i].sum, vecs[i].cout, (i == 0) ? 3 : 0);
      else
        op(1'b1, 1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, '0, '0, 1'b0,
           1'b0, vecs[i].sum, vecs[i].cout, (i == 0) ? 3 : 0);
    end

    // Random single-requester ops against the arithmetic reference.
    for (int i = 0; i < 8; i++) begin
      g = 1'($urandom);
      ra[0] = W'($urandom); rb[0] = W'($urandom); rc[0] = 1'($urandom);
      r = ref_add(ra[0], rb[0], rc[0]);
      op(!g, g, ra[0], rb[0], rc[0], ra[0], rb[0], rc[0],
         g, r[W-1:0], r[W], int'($urandom_range(0, 2)));
    end

    // Both requesters held valid from reset: grants alternate every 6 cycles.
    do_reset();
    last = 1'b1; pend = 1'b0; ngrant = 0; cyc = 0; prev_c = -1;
    for (int k = 0; k < 2; k++) begin
      ra[k] = W'($urandom); rb[k] = W'($urandom); rc[k] = 1'($urandom);
    end
    @(negedge clk);
    req0_a = ra[0]; req0_b = rb[0]; req0_cin = rc[0];
    req1_a = ra[1]; req1_b = rb[1]; req1_cin = rc[1];
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    while (ngrant < 8 && cyc < 200) begin
      #1;
      if (res_valid) begin
        chk("rr_pending", 32'(pend), 1);
        chk("rr_sum", 32'(res_sum), 32'(exp_s));
        chk("rr_cout", 32'(res_cout), 32'(exp_c));
        chk("rr_id", 32'(res_id), 32'(exp_i));
        pend = 1'b0;
      end
      if (req0_ready || req1_ready) begin
        g = !last;
        chk("rr_grant", 32'({req1_ready, req0_ready}), g ? 32'h2 : 32'h1);
        if (prev_c >= 0) chk("rr_spacing", 32'(cyc - prev_c), 6);
        prev_c = cyc;
        r = ref_add(ra[g], rb[g], rc[g]);
        exp_s = r[W-1:0]; exp_c = r[W]; exp_i = g; pend = 1'b1;
        last = g;
        ngrant++;
        @(posedge clk);
        #1;
        ra[g] = W'($urandom); rb[g] = W'($urandom); rc[g] = 1'($urandom);
        req0_a = ra[0]; req0_b = rb[0]; req0_cin = rc[0];
        req1_a = ra[1]; req1_b = rb[1]; req1_cin = rc[1];
      end
      @(negedge clk);
      cyc++;
    end
    chk("rr_grants", 32'(ngrant), 8);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("rr_last_sum", 32'(res_sum), 32'(exp_s));
    chk("rr_last_id", 32'(res_id), 32'(exp_i));
    @(negedge clk);
    res_ready = 1'b0;

    // Reset during nibble 2 aborts the operation.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0;
    #1;
    chk("abort_grant", 32'(req0_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= res_valid;
    end
    chk("abort_no_result", 32'(seen), 0);
    op(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0005, 16'h0005, 1'b0,
       1'b0, 16'h0002, 1'b0, 0);
    op(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0005, 16'h0005, 1'b0,
       1'b1, 16'h000A, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
